mdu_unit: RTL and testbench

//  E-stage multiply/divide unit. Consumes the decoder's mdu_ctrl, start and select codes

---
 rtl/mdu_unit.sv | 83 ++++++++
 tb/tb_mdu_unit.sv | 114 +++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit with HI/LO, busy-modelled latency; `MDU_DIV0_FAST_EN shortens divide-by-zero to 1 busy cycle
module mdu_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_ctrl,
  input  logic        start,
  input  logic        req,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] mdu_out
);
  localparam int MAXC = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
`ifdef MDU_DIV0_FAST_EN
  localparam int DIV0_CYCLES = 1;
`else
  localparam int DIV0_CYCLES = DIV_CYCLES;
`endif
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] hi, lo, hi_tmp, lo_tmp, hi_n, lo_n;
  logic [31:0] a_abs, b_abs, q_u, r_u, q, r;
  logic [63:0] prod;
  logic is_mul, is_div, is_signed, div0, neg_a, neg_b, go;
  always_comb begin
    is_mul = mdu_ctrl == 4'd5 || mdu_ctrl == 4'd6;
    is_div = mdu_ctrl == 4'd7 || mdu_ctrl == 4'd8;
    is_signed = mdu_ctrl == 4'd5 || mdu_ctrl == 4'd7;
    div0 = rt_data == 32'd0;
    go = start && (is_mul || is_div) && !req && !busy;
    // low 64 bits of the sign-extended product equal the signed 32x32 product
    prod = is_signed ? {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data}
                     : {32'd0, rs_data} * {32'd0, rt_data};
    neg_a = is_signed && rs_data[31];
    neg_b = is_signed && rt_data[31];
    a_abs = neg_a ? -rs_data : rs_data;
    b_abs = neg_b ? -rt_data : rt_data;
    q_u = a_abs / (div0 ? 32'd1 : b_abs);
    r_u = a_abs % (div0 ? 32'd1 : b_abs);
    q = (neg_a ^ neg_b) ? -q_u : q_u;
    r = neg_a ? -r_u : r_u;
    hi_n = is_mul ? prod[63:32] : div0 ? hi : r;
    lo_n = is_mul ? prod[31:0] : div0 ? lo : q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      hi_tmp <= '0;
      lo_tmp <= '0;
    end else if (state == IDLE) begin
      if (go) begin
        hi_tmp <= hi_n;
        lo_tmp <= lo_n;
        busy <= 1'b1;
        state <= is_mul ? MUL : DIV;
        cnt <= is_mul ? CW'(MUL_CYCLES) : div0 ? CW'(DIV0_CYCLES) : CW'(DIV_CYCLES);
      end else if (!req && mdu_ctrl == 4'd3) begin
        hi <= rs_data;
      end else if (!req && mdu_ctrl == 4'd4) begin
        lo <= rs_data;
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        hi <= hi_tmp;
        lo <= lo_tmp;
        cnt <= '0;
        busy <= 1'b0;
        state <= IDLE;
      end
    end
  end
  assign mdu_out = mdu_ctrl == 4'd1 ? hi : mdu_ctrl == 4'd2 ? lo : 32'd0;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: scoreboard bench for mdu_unit; expected HI:LO queued at issue, checked after busy drops
module tb_mdu_unit;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, req = 1'b0;
  logic [3:0] mdu_ctrl = 4'd0;
  logic [31:0] rs_data = 32'd0, rt_data = 32'd0;
  logic busy;
  logic [31:0] mdu_out;
  int n_chk = 0, n_pass = 0;
  logic [63:0] sb[$];
`ifdef MDU_DIV0_FAST_EN
  localparam int DIV0_N = 1;
`else
  localparam int DIV0_N = 10;
`endif
  always #5 clk = ~clk;
  mdu_unit dut (
    .clk(clk), .reset(reset), .mdu_ctrl(mdu_ctrl), .start(start), .req(req),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .mdu_out(mdu_out)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic read_hilo(input string tag);
    logic [63:0] e, g;
    e = sb.pop_front();
    mdu_ctrl = 4'd1;
    #1 g[63:32] = mdu_out;
    mdu_ctrl = 4'd2;
    #1 g[31:0] = mdu_out;
    mdu_ctrl = 4'd0;
    check(tag, g, e);
  endtask
  task automatic run(input string tag, input logic [3:0] c, input logic rq, input logic hr,
                     input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp, input int ncyc);
    int n;
    n = 0;
    sb.push_back(exp);
    mdu_ctrl = c; start = c >= 4'd5 && c <= 4'd8; req = rq; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    mdu_ctrl = 4'd0; start = 1'b0; req = hr;
    while (busy && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    req = 1'b0;
    check({tag, " busy"}, 64'(n), 64'(ncyc));
    read_hilo(tag);
  endtask
  initial begin
    logic [3:0] c;
    logic [31:0] a, b;
    logic [63:0] exp;
    int sa, sbv;
    longint unsigned ua, ub;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'd0);
    sb.push_back(64'd0);
    read_hilo("rst hilo");
    mdu_ctrl = 4'd3; rs_data = 32'h1234;
    @(posedge clk); #1;
    sb.push_back(64'd0);
    read_hilo("mthi in reset");
    reset = 1'b0; mdu_ctrl = 4'd3; rs_data = 32'h1234;
    @(posedge clk); #1;
    mdu_ctrl = 4'd0;
    sb.push_back({32'h1234, 32'h0});
    read_hilo("mthi after reset");
    run("mult", 4'd5, 0, 0, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE, 5);
    run("multu", 4'd6, 0, 0, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, 5);
    run("mult min", 4'd5, 0, 0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 5);
    run("div", 4'd7, 0, 0, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10);
    run("divu", 4'd8, 0, 0, 32'd7, 32'd2, 64'h00000001_00000003, 10);
    run("mthi", 4'd3, 0, 0, 32'hA, 32'd0, 64'h0000000A_00000003, 0);
    run("mtlo", 4'd4, 0, 0, 32'hB, 32'd0, 64'h0000000A_0000000B, 0);
    run("div0", 4'd7, 0, 0, 32'd5, 32'd0, 64'h0000000A_0000000B, DIV0_N);
    run("divu0", 4'd8, 0, 0, 32'd9, 32'd0, 64'h0000000A_0000000B, DIV0_N);
    run("mult req", 4'd5, 1, 0, 32'd3, 32'd4, 64'h0000000A_0000000B, 0);
    run("mtlo req", 4'd4, 1, 0, 32'h55, 32'd0, 64'h0000000A_0000000B, 0);
    run("invalid", 4'd9, 0, 0, 32'd3, 32'd4, 64'h0000000A_0000000B, 0);
    run("mult in-flight req", 4'd5, 0, 1, 32'd3, 32'd4, 64'd12, 5);
    for (int i = 0; i < 6; i++) begin
      c = 4'($urandom_range(5, 8));
      a = $urandom;
      b = 32'($urandom_range(2, 1000));
      if ($urandom_range(0, 1) == 1) b = -b;
      sa = a; sbv = b; ua = 64'(a); ub = 64'(b);
      exp = c == 4'd5 ? 64'(longint'(sa) * longint'(sbv)) :
            c == 4'd6 ? ua * ub :
            c == 4'd7 ? {32'(sa % sbv), 32'(sa / sbv)} : {a % b, a / b};
      run("rand", c, 0, 0, a, b, exp, c < 4'd7 ? 5 : 10);
    end
    mdu_ctrl = 4'd8; start = 1'b1; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge clk); #1;
    mdu_ctrl = 4'd0; start = 1'b0;
    check("divu busy1", 64'(busy), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    sb.push_back(64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset mid busy", 64'(busy), 64'd0);
    read_hilo("reset mid hilo");
    repeat (12) @(posedge clk);
    #1;
    sb.push_back(64'd0);
    read_hilo("no late commit");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
